// File: rtl/vp_pkg.sv
// vp_pkg: shared mode/state encodings and default frame geometry for the frame writer
package vp_pkg;
  localparam int H_DEF = 640;
  localparam int V_DEF = 480;
  typedef enum logic [1:0] {M_PASS, M_GRAY, M_THRESH, M_INVERT} mode_t;
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_STREAM, S_DONE} state_t;
endpackage

// File: rtl/vp_frame_writer_if.sv
// vp_frame_writer_if: upstream pixel handshake (valid/ready/data) and frame-buffer write port (en/addr/data/ready)
interface vp_frame_writer_if #(parameter int AW = 19);
  logic          i_data_valid;
  logic          o_data_ready;
  logic [11:0]   i_data;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [11:0]   o_wr_data;
  logic          i_fb_ready;
  modport slave (input i_data_valid, i_data, i_fb_ready, output o_data_ready, o_wr_en, o_wr_addr, o_wr_data);
  modport master (output i_data_valid, i_data, i_fb_ready, input o_data_ready, o_wr_en, o_wr_addr, o_wr_data);
endinterface

// File: rtl/vp_pix_map.sv
// vp_pix_map: 2-stage pixel pipe (stage 1 pixel+luma, stage 2 mapped data+addr+valid); in_ready=stage 1 free, out_ready stalls stage 2
module vp_pix_map import vp_pkg::*; #(
  parameter int AW = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [11:0]   in_data,
  input  logic [AW-1:0] in_addr,
  input  mode_t         mode,
  input  logic [3:0]    thresh,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [11:0]   out_data
);
  logic          en1, en2;
  logic [7:0]    sum;
  logic          v1_q, v1_d, v2_q, v2_d;
  logic [11:0]   px_q, px_d, d2_q, d2_d;
  logic [3:0]    lu_q, lu_d;
  logic [AW-1:0] a1_q, a1_d, a2_q, a2_d;
  assign en2 = !v2_q || out_ready;
  assign en1 = !v1_q || en2;
  assign in_ready = en1;
  always_comb begin
    sum  = 8'd5 * {4'd0, in_data[11:8]} + 8'd9 * {4'd0, in_data[7:4]} + 8'd2 * {4'd0, in_data[3:0]};
    v1_d = en1 ? in_valid : v1_q;
    px_d = en1 ? in_data : px_q;
    lu_d = en1 ? 4'(sum >> 4) : lu_q;
    a1_d = en1 ? in_addr : a1_q;
    v2_d = en2 ? v1_q : v2_q;
    a2_d = en2 ? a1_q : a2_q;
    d2_d = !en2 ? d2_q :
           mode == M_PASS ? px_q :
           mode == M_GRAY ? {3{lu_q}} :
           mode == M_THRESH ? {12{lu_q >= thresh}} : ~px_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      v1_q <= 1'b0;
      px_q <= '0;
      lu_q <= '0;
      a1_q <= '0;
      v2_q <= 1'b0;
      a2_q <= '0;
      d2_q <= '0;
    end else begin
      v1_q <= v1_d;
      px_q <= px_d;
      lu_q <= lu_d;
      a1_q <= a1_d;
      v2_q <= v2_d;
      a2_q <= a2_d;
      d2_q <= d2_d;
    end
  assign out_valid = v2_q;
  assign out_addr  = a2_q;
  assign out_data  = d2_q;
endmodule

// File: rtl/vp_frame_writer.sv
// vp_frame_writer: streams one RGB444 frame through a luma/mode map into a linear frame buffer; ports: i_clk/i_rst, start/continuous/mode/thresh controls, bus (upstream + fb), busy/frame_done status
module vp_frame_writer import vp_pkg::*; #(
  parameter int H_ACTIVE = H_DEF,
  parameter int V_ACTIVE = V_DEF,
  parameter int AW       = 19
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_continuous,
  input  logic [1:0] i_mode,
  input  logic [3:0] i_thresh,
  vp_frame_writer_if.slave bus,
  output logic       o_busy,
  output logic       o_frame_done
);
  localparam int XW = H_ACTIVE > 1 ? $clog2(H_ACTIVE) : 1;
  localparam int YW = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
  localparam logic [AW-1:0] LAST = AW'(H_ACTIVE * V_ACTIVE - 1);
  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          got_last_q, got_last_d, busy_q, busy_d, done_q, done_d;
  mode_t         mode_q, mode_d;
  logic [3:0]    thresh_q, thresh_d;
  logic          s1_rdy, accept, last_px, wr_last;
  assign bus.o_data_ready = (state_q == S_ARMED || state_q == S_STREAM) && s1_rdy && !got_last_q;
  assign accept = bus.i_data_valid && bus.o_data_ready;
  assign last_px = x_q == XW'(H_ACTIVE - 1) && y_q == YW'(V_ACTIVE - 1);
  assign wr_last = bus.o_wr_en && bus.i_fb_ready && bus.o_wr_addr == LAST;
  always_comb begin
    state_d = state_q == S_IDLE ? (i_start ? S_ARMED : S_IDLE) :
              state_q == S_ARMED ? (accept ? S_STREAM : S_ARMED) :
              state_q == S_STREAM ? (wr_last ? S_DONE : S_STREAM) :
              (i_continuous ? S_ARMED : S_IDLE);
    x_d = !accept ? x_q : x_q == XW'(H_ACTIVE - 1) ? '0 : x_q + XW'(1);
    y_d = !(accept && x_q == XW'(H_ACTIVE - 1)) ? y_q : y_q == YW'(V_ACTIVE - 1) ? '0 : y_q + YW'(1);
    addr_d = !accept ? addr_q : last_px ? '0 : addr_q + AW'(1);
    // once the final pixel is taken, upstream stays blocked until the frame retires
    got_last_d = state_q == S_DONE ? 1'b0 : got_last_q || (accept && last_px);
    mode_d = state_q == S_ARMED && accept ? mode_t'(i_mode) : mode_q;
    thresh_d = state_q == S_ARMED && accept ? i_thresh : thresh_q;
    busy_d = state_d != S_IDLE;
    done_d = wr_last;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      got_last_q <= 1'b0;
      mode_q     <= M_PASS;
      thresh_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      got_last_q <= got_last_d;
      mode_q     <= mode_d;
      thresh_q   <= thresh_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  vp_pix_map #(.AW(AW)) u_map (
    .clk(i_clk),
    .rst(i_rst),
    .in_valid(accept),
    .in_data(bus.i_data),
    .in_addr(addr_q),
    .mode(mode_q),
    .thresh(thresh_q),
    .out_ready(bus.i_fb_ready),
    .in_ready(s1_rdy),
    .out_valid(bus.o_wr_en),
    .out_addr(bus.o_wr_addr),
    .out_data(bus.o_wr_data)
  );
  assign o_busy = busy_q;
  assign o_frame_done = done_q;
endmodule
